freq_bcd_counter: RTL

- Downstream stage of the gate/timebase controller in the frequency meter. It consumes `counter_en`, `cnt_clr_n` and `latch`, and counts rising edges of the measured signal during the gate window.
- The count is held in a multi-digit BCD counter.
- On each latch edge the count is copied into a stable output register that feeds the display driver.

---
 rtl/freq_bcd_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/freq_bcd_counter.sv
// Frequency-meter BCD edge counter with latched display output; FREQ_BLANK_LZ_EN blanks leading zeros at capture.
// Latency: sig_in/latch rise first sampled at edge k is visible after edge k+SYNC_STAGES (k+2 by default).
// Backpressure: none; valid is a single-cycle pulse and bcd_out/ovf_out hold until the next capture.
module freq_bcd_counter #(
    parameter int DIGITS      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sig_in,
    input  logic                  counter_en,
    input  logic                  cnt_clr_n,
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf_out,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   count_live
);
    localparam int W = 4 * DIGITS;

    logic [SYNC_STAGES-1:0] sig_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] lat_sync;
    logic                   sig_in_s;
    logic                   counter_en_s;
    logic                   cnt_clr_n_s;
    logic                   latch_s;
    logic                   sig_in_d;
    logic                   latch_d;
    logic                   rise;
    logic                   lrise;

    logic [W-1:0]           count_q;
    logic [W-1:0]           count_inc;
    logic [W-1:0]           capture_val;
    logic                   ovf_q;
    logic                   all_nines;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_sync <= '0;
            en_sync  <= '0;
            clr_sync <= '0;
            lat_sync <= '0;
            sig_in_d <= 1'b0;
            latch_d  <= 1'b0;
        end else begin
            sig_sync <= {sig_sync[SYNC_STAGES-2:0], sig_in};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], counter_en};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], cnt_clr_n};
            lat_sync <= {lat_sync[SYNC_STAGES-2:0], latch};
            sig_in_d <= sig_in_s;
            latch_d  <= latch_s;
        end
    end

    assign sig_in_s     = sig_sync[SYNC_STAGES-1];
    assign counter_en_s = en_sync[SYNC_STAGES-1];
    assign cnt_clr_n_s  = clr_sync[SYNC_STAGES-1];
    assign latch_s      = lat_sync[SYNC_STAGES-1];
    assign rise         = sig_in_s & ~sig_in_d;
    assign lrise        = latch_s & ~latch_d;

    // Single-cycle ripple: all_nines ends high only if every digit wrapped.
    always_comb begin
        count_inc = count_q;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (all_nines) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    all_nines = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (!cnt_clr_n_s) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (rise && counter_en_s) begin
            if (all_nines) begin
                ovf_q <= 1'b1;
            end else begin
                count_q <= count_inc;
            end
        end
    end

`ifdef FREQ_BLANK_LZ_EN
    // Leading zeros become 4'hF for the display driver; digit 0 always shows.
    always_comb begin
        logic lead;
        capture_val = count_q;
        lead        = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (count_q[4*i +: 4] == 4'd0)) begin
                capture_val[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign capture_val = count_q;
`endif

    // Capture samples the pre-update count, so a same-cycle clear or increment is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_out <= '0;
            ovf_out <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= lrise;
            if (lrise) begin
                bcd_out <= capture_val;
                ovf_out <= ovf_q;
            end
        end
    end

    assign count_live = count_q;

endmodule
